// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline forwarding/stall/flush control with multi-cycle divider sequencer
module hazard_unit #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteE,
    input  logic       regwriteM,
    input  logic       regwriteW,
    input  logic       memtoregE,
    input  logic       memtoregM,
    input  logic       branchD,
    input  logic       pcsrcD,
    input  logic       div_startE,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       forwardAD,
    output logic       forwardBD,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic       div_busy,
    output logic       div_done
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} div_state_t;

    div_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    logic m_hit_rsE, m_hit_rtE, w_hit_rsE, w_hit_rtE;
    logic lwstall, branchstall, busy, done;

    // Register $0 is hardwired, so a write to it never creates a dependency.
    assign m_hit_rsE = regwriteM && (writeregM != 5'd0) && (writeregM == rsE);
    assign m_hit_rtE = regwriteM && (writeregM != 5'd0) && (writeregM == rtE);
    assign w_hit_rsE = regwriteW && (writeregW != 5'd0) && (writeregW == rsE);
    assign w_hit_rtE = regwriteW && (writeregW != 5'd0) && (writeregW == rtE);

    assign lwstall = memtoregE && (rtE != 5'd0) && ((rtE == rsD) || (rtE == rtD));

    assign branchstall = branchD &&
        ((regwriteE && (writeregE != 5'd0) && ((writeregE == rsD) || (writeregE == rtD))) ||
         (memtoregM && (writeregM != 5'd0) && ((writeregM == rsD) || (writeregM == rtD))));

    assign busy = (state == BUSY);
    assign done = busy && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (div_startE) begin
                    state_next = BUSY;
                    cnt_next   = CNT_W'(DIV_CYCLES - 1);
                end
            end
            BUSY: begin
                // A new start while busy is dropped; the divider only has one slot.
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        forwardAD = 1'b0;
        forwardBD = 1'b0;
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        flushD    = 1'b1;
        flushE    = 1'b1;
        flushM    = 1'b1;
        div_busy  = 1'b0;
        div_done  = 1'b0;
        if (!rst) begin
            forwardAE = m_hit_rsE ? 2'b10 : (w_hit_rsE ? 2'b01 : 2'b00);
            forwardBE = m_hit_rtE ? 2'b10 : (w_hit_rtE ? 2'b01 : 2'b00);
            forwardAD = regwriteM && (writeregM != 5'd0) && (writeregM == rsD);
            forwardBD = regwriteM && (writeregM != 5'd0) && (writeregM == rtD);
            div_busy  = busy;
            div_done  = done;
            stallE    = busy;
            stallD    = lwstall || branchstall || busy;
            stallF    = lwstall || branchstall || busy;
            // The divide keeps ID/EX frozen, so bubbles go into M instead of EX.
            flushM    = busy && !done;
            flushE    = (lwstall || branchstall) && !busy;
            flushD    = pcsrcD && !(lwstall || branchstall || busy);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic       branchD, pcsrcD, div_startE;
    logic [1:0] forwardAE, forwardBE;
    logic       forwardAD, forwardBD;
    logic       stallF, stallD, stallE, flushD, flushE, flushM, div_busy, div_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_unit #(.DIV_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .pcsrcD(pcsrcD), .div_startE(div_startE),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .div_busy(div_busy), .div_done(div_done)
    );

    // ctl bit order: stallF stallD stallE flushD flushE flushM div_busy div_done
    function automatic logic [7:0] ctl();
        return {stallF, stallD, stallE, flushD, flushE, flushM, div_busy, div_done};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic clr();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeregE = 0; writeregM = 0; writeregW = 0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0;
        memtoregE = 0; memtoregM = 0;
        branchD = 0; pcsrcD = 0; div_startE = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] div_exp [1:5];
    logic [7:0] divlw_exp [1:5];

    initial begin
        div_exp   = '{8'b11100110, 8'b11100110, 8'b11100110, 8'b11100011, 8'b00000000};
        divlw_exp = '{8'b11100110, 8'b11100110, 8'b11100110, 8'b11100011, 8'b11001000};

        // Reset with hazards present on the inputs: outputs must be forced
        clr();
        rst = 1;
        memtoregE = 1; rtE = 8; rsD = 8; rsE = 8;
        regwriteM = 1; writeregM = 8; pcsrcD = 1;
        step();
        check("rst_ctl", ctl(), 8'b00011100);
        check("rst_fwd", {2'b00, forwardAE, forwardBE, forwardAD, forwardBD}, 8'h00);

        rst = 0;
        clr();
        #1;
        check("idle_ctl", ctl(), 8'h00);

        // EX forwarding priority and $0 exclusion
        regwriteM = 1; writeregM = 5; regwriteW = 1; writeregW = 5; rsE = 5; rtE = 5;
        #1 check("fwdE_m", {4'b0, forwardAE, forwardBE}, 8'b00001010);
        regwriteM = 0;
        #1 check("fwdE_w", {4'b0, forwardAE, forwardBE}, 8'b00000101);
        regwriteM = 1; writeregM = 0; writeregW = 0; rsE = 0; rtE = 0;
        #1 check("fwdE_r0", {4'b0, forwardAE, forwardBE}, 8'b00000000);

        // ID forwarding: only from M
        clr();
        regwriteM = 1; writeregM = 7; rsD = 7; rtD = 2;
        #1 check("fwdD_m", {6'b0, forwardAD, forwardBD}, 8'b00000010);
        regwriteM = 0; regwriteW = 1; writeregW = 7;
        #1 check("fwdD_w", {6'b0, forwardAD, forwardBD}, 8'b00000000);

        // Load-use
        clr();
        memtoregE = 1; rtE = 8; rsD = 8;
        #1 check("lw_stall", ctl(), 8'b11001000);
        step();
        memtoregE = 0;
        #1 check("lw_clear", ctl(), 8'h00);
        memtoregE = 1; rtE = 0; rsD = 0;
        #1 check("lw_r0", ctl(), 8'h00);

        // Branch compare stalls and taken-branch flush
        clr();
        branchD = 1; rsD = 3; regwriteE = 1; writeregE = 3; pcsrcD = 1;
        #1 check("br_stallE", ctl(), 8'b11001000);
        clr();
        branchD = 1; rtD = 4; memtoregM = 1; writeregM = 4; pcsrcD = 1;
        #1 check("br_stallM", ctl(), 8'b11001000);
        clr();
        branchD = 1; rsD = 3; pcsrcD = 1;
        #1 check("br_taken", ctl(), 8'b00010000);

        // Divide, with a second start ignored mid-busy
        clr();
        div_startE = 1;
        #1 check("div_pre", ctl(), 8'h00);
        for (int i = 1; i <= 5; i++) begin
            step();
            div_startE = (i == 1);
            #1 check($sformatf("div_c%0d", i), ctl(), div_exp[i]);
        end

        // Divide overlapping a load-use hazard
        clr();
        div_startE = 1;
        step();
        div_startE = 0;
        memtoregE = 1; rtE = 8; rsD = 8;
        #1 check("divlw_c1", ctl(), divlw_exp[1]);
        for (int i = 2; i <= 5; i++) begin
            step();
            check($sformatf("divlw_c%0d", i), ctl(), divlw_exp[i]);
        end

        // Reset aborts a divide
        clr();
        div_startE = 1;
        step();
        div_startE = 0;
        step();
        check("abort_busy", ctl(), 8'b11100110);
        rst = 1;
        #1 check("abort_rst", ctl(), 8'b00011100);
        step();
        check("abort_rst2", ctl(), 8'b00011100);
        rst = 0;
        #1 check("abort_idle", ctl(), 8'h00);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("abort_post%0d", i), {6'b0, div_busy, div_done}, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
